// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS Montgomery datapath blocks.
package fios_pkg;

  localparam int unsigned WORD_WIDTH = 17;
  localparam int unsigned P_WIDTH    = 34;
  localparam int unsigned WORD_COUNT = 16;
  localparam int unsigned IDX_WIDTH  = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } fios_res_state_t;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/fios_result_unit_if.sv
// Input word stream from the PE chain plus the valid/ready result stream.
interface fios_result_unit_if #(
    parameter int unsigned WORD_WIDTH = fios_pkg::WORD_WIDTH,
    parameter int unsigned P_WIDTH    = fios_pkg::P_WIDTH
);
    logic                  start_i;
    logic                  word_valid_i;
    logic [P_WIDTH-1:0]    word_i;
    logic [WORD_WIDTH-1:0] m_word_i;
    logic                  res_ready_i;
    logic                  busy_o;
    logic                  res_valid_o;
    logic [WORD_WIDTH-1:0] res_word_o;
    logic                  res_last_o;
    logic                  range_err_o;
    logic                  protocol_err_o;

    modport master (
        output start_i, word_valid_i, word_i, m_word_i, res_ready_i,
        input  busy_o, res_valid_o, res_word_o, res_last_o, range_err_o, protocol_err_o
    );

    modport slave (
        input  start_i, word_valid_i, word_i, m_word_i, res_ready_i,
        output busy_o, res_valid_o, res_word_o, res_last_o, range_err_o, protocol_err_o
    );
endinterface

// File: rtl/fios_dual_word_buffer.sv
// Twin word buffers for T and T-M sharing one write index; read port picks one by sel_i.
module fios_dual_word_buffer #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned WORD_COUNT = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [WORD_WIDTH-1:0] wdata_t_i,
    input  logic [WORD_WIDTH-1:0] wdata_d_i,
    input  logic [IDX_W-1:0]      ridx_i,
    input  logic                  sel_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] buf_t_q [WORD_COUNT];
    logic [WORD_WIDTH-1:0] buf_d_q [WORD_COUNT];

    // Contents are don't-care after reset, so no reset on the arrays.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            buf_t_q[widx_i] <= wdata_t_i;
            buf_d_q[widx_i] <= wdata_d_i;
        end
    end

    assign rdata_o = sel_i ? buf_d_q[ridx_i] : buf_t_q[ridx_i];

endmodule

// File: rtl/fios_result_unit.sv
// Carry-normalises the last PE's partial words, forms T and T-M on the fly and
// drains the reduced Montgomery result LSW first.
module fios_result_unit #(
    parameter int unsigned WORD_WIDTH = fios_pkg::WORD_WIDTH,
    parameter int unsigned P_WIDTH    = fios_pkg::P_WIDTH,
    parameter int unsigned WORD_COUNT = fios_pkg::WORD_COUNT
) (
    input logic               clock_i,
    input logic               reset_n_i,
    fios_result_unit_if.slave bus
);
    import fios_pkg::*;

    localparam int unsigned IdxW   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int unsigned SumW   = P_WIDTH + 1;
    localparam int unsigned CarryW = SumW - WORD_WIDTH;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_COUNT - 1);

    fios_res_state_t state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CarryW-1:0] carry_q, carry_d;
    logic              borrow_q, borrow_d;
    logic              sel_q, sel_d;
    logic              range_err_q, range_err_d;
    logic              proto_err_q, proto_err_d;

    logic                  accept;
    logic                  last_word;
    logic [SumW-1:0]       sum;
    logic [WORD_WIDTH-1:0] t_word;
    logic [CarryW-1:0]     carry_nxt;
    logic [WORD_WIDTH:0]   diff;
    logic [WORD_WIDTH-1:0] d_word;
    logic                  borrow_nxt;
    logic [WORD_WIDTH-1:0] rdata;

    assign accept    = (state_q == ACCUM) && bus.word_valid_i;
    assign last_word = (idx_q == LastIdx);

    assign sum        = {1'b0, bus.word_i} + SumW'(carry_q);
    assign t_word     = sum[WORD_WIDTH-1:0];
    assign carry_nxt  = sum[SumW-1:WORD_WIDTH];
    assign diff       = {1'b0, t_word} - {1'b0, bus.m_word_i} - (WORD_WIDTH + 1)'(borrow_q);
    assign d_word     = diff[WORD_WIDTH-1:0];
    assign borrow_nxt = diff[WORD_WIDTH];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = ACCUM;
            ACCUM:   if (accept && last_word) state_d = DRAIN;
            DRAIN:   if (bus.res_ready_i && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o      = (state_q != IDLE);
        bus.res_valid_o = (state_q == DRAIN);
        bus.res_word_o  = (state_q == DRAIN) ? rdata : '0;
        bus.res_last_o  = (state_q == DRAIN) && last_word;
    end

    always_comb begin
        idx_d       = idx_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        sel_d       = sel_q;
        range_err_d = range_err_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    idx_d       = '0;
                    carry_d     = '0;
                    borrow_d    = 1'b0;
                    range_err_d = 1'b0;
                    proto_err_d = 1'b0;
                end else if (bus.word_valid_i) begin
                    proto_err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    carry_d  = carry_nxt;
                    borrow_d = borrow_nxt;
                    idx_d    = idx_q + IdxW'(1);
                    if (last_word) begin
                        // Final carry or no final borrow means T >= M: drain T-M.
                        sel_d = (carry_nxt != '0) || !borrow_nxt;
                        // (carry - borrow) > 1, kept unsigned.
                        if (carry_nxt > (borrow_nxt ? CarryW'(2) : CarryW'(1))) begin
                            range_err_d = 1'b1;
                        end
                        idx_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (bus.word_valid_i) proto_err_d = 1'b1;
                if (bus.res_ready_i) idx_d = last_word ? '0 : idx_q + IdxW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q       <= '0;
            carry_q     <= '0;
            borrow_q    <= 1'b0;
            sel_q       <= 1'b0;
            range_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            sel_q       <= sel_d;
            range_err_q <= range_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.range_err_o    = range_err_q;
    assign bus.protocol_err_o = proto_err_q;

    fios_dual_word_buffer #(
        .WORD_WIDTH(WORD_WIDTH),
        .WORD_COUNT(WORD_COUNT),
        .IDX_W     (IdxW)
    ) u_buf (
        .clk_i    (clock_i),
        .we_i     (accept),
        .widx_i   (idx_q),
        .wdata_t_i(t_word),
        .wdata_d_i(d_word),
        .ridx_i   (idx_q),
        .sel_i    (sel_q),
        .rdata_o  (rdata)
    );

endmodule

// File: tb/tb_fios_result_unit.sv
// Directed bench for fios_result_unit with WORD_COUNT=4: vector table plus corner sequences.
module tb_fios_result_unit;

    localparam int unsigned WW = 17;
    localparam int unsigned PW = 34;
    localparam int unsigned WC = 4;

    typedef struct {
        logic [WC-1:0][WW-1:0] m;     // MSW first in literals: {w3,w2,w1,w0}
        logic [WC-1:0][PW-1:0] w;
        logic [WC-1:0][WW-1:0] e;
        logic                  rerr;
        logic                  gap;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [6];

    fios_result_unit_if #(.WORD_WIDTH(WW), .P_WIDTH(PW)) bus ();

    fios_result_unit #(
        .WORD_WIDTH(WW),
        .P_WIDTH   (PW),
        .WORD_COUNT(WC)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic feed(input vec_t v);
        for (int i = 0; i < WC; i++) begin
            if (v.gap && i == 2) begin
                bus.word_valid_i = 1'b0;
                bus.word_i       = '1;
                tick();
            end
            bus.word_valid_i = 1'b1;
            bus.word_i       = v.w[i];
            bus.m_word_i     = v.m[i];
            tick();
        end
        bus.word_valid_i = 1'b0;
    endtask

    task automatic drain_check(input vec_t v, input string tag);
        bus.res_ready_i = 1'b1;
        for (int i = 0; i < WC; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 64'(bus.res_valid_o), 64'd1);
            check($sformatf("%s word[%0d]", tag, i), 64'(bus.res_word_o), 64'(v.e[i]));
            check($sformatf("%s last[%0d]", tag, i), 64'(bus.res_last_o), 64'(i == WC - 1));
            tick();
        end
        bus.res_ready_i = 1'b0;
        check({tag, " valid_end"}, 64'(bus.res_valid_o), 64'd0);
        check({tag, " busy_end"}, 64'(bus.busy_o), 64'd0);
        check({tag, " range_err"}, 64'(bus.range_err_o), 64'(v.rerr));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0].m = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vecs[0].w = {34'h0, 34'h0, 34'h0, 34'h00001};
        vecs[0].e = {17'h0, 17'h0, 17'h0, 17'h00001};
        vecs[0].rerr = 1'b0; vecs[0].gap = 1'b0;

        vecs[1].m = {17'h0, 17'h0, 17'h0, 17'h00005};
        vecs[1].w = {34'h0, 34'h0, 34'h0, 34'h3FFFF};
        vecs[1].e = {17'h0, 17'h0, 17'h00001, 17'h1FFFA};
        vecs[1].rerr = 1'b0; vecs[1].gap = 1'b0;

        vecs[2].m = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vecs[2].w = {34'h20000, 34'h0, 34'h0, 34'h0};
        vecs[2].e = {17'h0, 17'h0, 17'h0, 17'h00001};
        vecs[2].rerr = 1'b0; vecs[2].gap = 1'b0;

        vecs[3].m = {17'h00001, 17'h1FFFF, 17'h00ABC, 17'h12345};
        vecs[3].w = {34'h00001, 34'h1FFFF, 34'h00ABC, 34'h12345};
        vecs[3].e = {17'h0, 17'h0, 17'h0, 17'h0};
        vecs[3].rerr = 1'b0; vecs[3].gap = 1'b1;

        // Final carry 3, borrow 1: T >= 2M.
        vecs[4].m = {17'h0, 17'h0, 17'h0, 17'h00001};
        vecs[4].w = {34'h60000, 34'h0, 34'h0, 34'h0};
        vecs[4].e = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vecs[4].rerr = 1'b1; vecs[4].gap = 1'b0;

        // Carry of 2 ripples from word 1 into word 2.
        vecs[5].m = {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        vecs[5].w = {34'h0, 34'h0, 34'h3FFFF, 34'h3FFFF};
        vecs[5].e = {17'h0, 17'h00002, 17'h0, 17'h1FFFF};
        vecs[5].rerr = 1'b0; vecs[5].gap = 1'b0;

        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.word_valid_i = 1'b0;
        bus.word_i       = '0;
        bus.m_word_i     = '0;
        bus.res_ready_i  = 1'b0;
        tick();
        check("rst busy", 64'(bus.busy_o), 64'd0);
        check("rst valid", 64'(bus.res_valid_o), 64'd0);
        check("rst word", 64'(bus.res_word_o), 64'd0);
        check("rst last", 64'(bus.res_last_o), 64'd0);
        check("rst range_err", 64'(bus.range_err_o), 64'd0);
        check("rst proto_err", 64'(bus.protocol_err_o), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            start_run();
            check($sformatf("v%0d busy_accum", k), 64'(bus.busy_o), 64'd1);
            feed(vecs[k]);
            drain_check(vecs[k], $sformatf("v%0d", k));
            check($sformatf("v%0d proto_err", k), 64'(bus.protocol_err_o), 64'd0);
        end

        // Backpressure on word 1, start_i in DRAIN and on the last transfer ignored.
        start_run();
        feed(vecs[1]);
        bus.res_ready_i = 1'b1;
        check("bp word0", 64'(bus.res_word_o), 64'h1FFFA);
        tick();
        bus.res_ready_i = 1'b0;
        bus.start_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp valid_hold%0d", i), 64'(bus.res_valid_o), 64'd1);
            check($sformatf("bp word_hold%0d", i), 64'(bus.res_word_o), 64'h00001);
            check($sformatf("bp last_hold%0d", i), 64'(bus.res_last_o), 64'd0);
        end
        bus.start_i     = 1'b0;
        bus.res_ready_i = 1'b1;
        check("bp word1", 64'(bus.res_word_o), 64'h00001);
        tick();
        check("bp word2", 64'(bus.res_word_o), 64'h0);
        check("bp last2", 64'(bus.res_last_o), 64'd0);
        tick();
        check("bp last3", 64'(bus.res_last_o), 64'd1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        bus.res_ready_i = 1'b0;
        check("bp start_on_last busy", 64'(bus.busy_o), 64'd0);
        tick();
        check("bp idle_after busy", 64'(bus.busy_o), 64'd0);

        // word_valid_i during DRAIN is dropped and flags protocol_err_o until next start.
        start_run();
        feed(vecs[0]);
        bus.word_valid_i = 1'b1;
        bus.word_i       = 34'h3FFFF;
        tick();
        bus.word_valid_i = 1'b0;
        check("pe drain word", 64'(bus.res_word_o), 64'h00001);
        check("pe drain flag", 64'(bus.protocol_err_o), 64'd1);
        drain_check(vecs[0], "pe");
        check("pe flag_idle", 64'(bus.protocol_err_o), 64'd1);
        start_run();
        check("pe flag_cleared", 64'(bus.protocol_err_o), 64'd0);
        feed(vecs[5]);
        drain_check(vecs[5], "pe2");
        bus.word_valid_i = 1'b1;
        tick();
        bus.word_valid_i = 1'b0;
        check("pe idle_word flag", 64'(bus.protocol_err_o), 64'd1);
        check("pe idle_word busy", 64'(bus.busy_o), 64'd0);

        // Reset after two ACCUM words, then a clean run.
        start_run();
        for (int i = 0; i < 2; i++) begin
            bus.word_valid_i = 1'b1;
            bus.word_i       = 34'h3FFFF;
            bus.m_word_i     = 17'h00005;
            tick();
        end
        bus.word_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr busy", 64'(bus.busy_o), 64'd0);
        check("mr valid", 64'(bus.res_valid_o), 64'd0);
        check("mr word", 64'(bus.res_word_o), 64'd0);
        check("mr last", 64'(bus.res_last_o), 64'd0);
        check("mr proto_err", 64'(bus.protocol_err_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_run();
        feed(vecs[1]);
        drain_check(vecs[1], "mr_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fios_result_unit.md
Name: fios_result_unit

Overview:
- Downstream consumer of the last FIOS processing element's DSP output (34-bit redundant partial words, one per cycle, least significant word first).
- Carry-normalises the stream into 17-bit words.
- Computes T-M on the fly and buffers both T and T-M.
- Drains the reduced Montgomery result (T or T-M) over a valid/ready output stream.

Parameters:
- WORD_WIDTH, 17, width of one normalised word (DSP unsigned operand width).
- P_WIDTH, 34, width of incoming partial word (DSP P output bits used).
- WORD_COUNT, 16, number of words s per operand; result is WORD_COUNT*WORD_WIDTH bits.

Ports:
- clock_i  in  1  single clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  pulse; arms block for a new result (honoured only in IDLE).
- word_valid_i  in  1  word_i/m_word_i valid this cycle (no backpressure; DSP pipeline cannot stall).
- word_i  in  P_WIDTH  partial result word from PE chain.
- m_word_i  in  WORD_WIDTH  modulus word with the same index as word_i.
- busy_o  out  1  high in ACCUM or DRAIN.
- res_valid_o  out  1  output word valid.
- res_ready_i  in  1  sink ready.
- res_word_o  out  WORD_WIDTH  reduced result word, LSW first.
- res_last_o  out  1  marks word WORD_COUNT-1.
- range_err_o  out  1  sticky; final T >= 2M detected.
- protocol_err_o  out  1  sticky; word_valid_i outside ACCUM.

Behaviour:
- Reset (async assert, sync deassert handled externally): state IDLE; all outputs 0; idx, carry and borrow cleared. Buffer contents don't care.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start_i: go to ACCUM; clear idx, carry (18 bits), borrow, range_err_o and protocol_err_o.
  - word_valid_i without start_i: ignored; sets protocol_err_o.
- ACCUM, per accepted word (word_valid_i=1):
  - sum = word_i + carry (35 bits); t = sum[16:0]; carry <= sum >> 17.
  - {bout, d} = t - m_word_i - borrow (18-bit); borrow <= bout.
  - buf_t[idx] <= t; buf_d[idx] <= d; idx++.
  - No-word cycles hold all state.
- End of ACCUM: the word with idx=WORD_COUNT-1 is accepted. In that same cycle, using the next-state carry and borrow:
  - sel_d <= (carry_next != 0) || !borrow_next.
  - range_err_o set if (carry_next - borrow_next) > 1.
  - Go to DRAIN; idx <= 0.
- DRAIN:
  - res_valid_o=1 from the cycle after the last input word.
  - res_word_o = sel_d ? buf_d[idx] : buf_t[idx]. Registered output: word and last stay stable while valid && !ready.
  - Transfer on valid && ready; idx++.
  - res_last_o=1 when idx=WORD_COUNT-1.
  - After the last transfer: res_valid_o=0 next cycle; go to IDLE. A start_i on the same cycle as the last transfer is ignored; the next one is honoured in IDLE.
- Latency: 1 cycle from last input word to first res_valid_o. Best-case drain is WORD_COUNT cycles.
- start_i in ACCUM/DRAIN: ignored.
- word_valid_i in DRAIN: word dropped; protocol_err_o set.
- Reset mid-operation: immediate return to IDLE, outputs 0, no partial output.
- Width rules: carry never exceeds 2^18-1 (34-bit input plus 18-bit carry). Subtraction result modulo 2^17 per word. Output truncated to WORD_COUNT words (valid since result < M when range_err_o=0).

Decomposition:
- Shared package fios_pkg:
  - WORD_WIDTH, P_WIDTH, WORD_COUNT defaults.
  - Derived IDX_WIDTH = $clog2(WORD_COUNT).
  - Typedef fios_res_state_t {IDLE, ACCUM, DRAIN}.
  - Typedef word_t logic [WORD_WIDTH-1:0].
- One sub-module fios_dual_word_buffer: two WORD_COUNT x WORD_WIDTH register arrays, shared write index, two write data, one read index, select input. Keeps the top level to FSM plus arithmetic.

Test Plan:
- WORD_COUNT=4, M words all 0x1FFFF; inputs 0x00001,0,0,0 -> T<M -> outputs 0x00001,0,0,0; res_last_o on 4th; range_err_o=0.
- Carry propagation: M=0x00005,0,0,0; inputs 0x3FFFF,0,0,0 -> T=0x3FFFF >= M -> outputs 0x1FFFA,0x00001,0,0.
- Final carry selects D: M all 0x1FFFF; inputs 0,0,0,0x20000 -> carry=1 -> outputs 0x00001,0,0,0.
- T==M: inputs equal M words (0x12345,0x00ABC,0x1FFFF,0x00001) -> borrow=0 -> outputs 0,0,0,0.
- Backpressure: res_ready_i low 3 cycles at word 1 -> res_word_o/res_last_o stable, res_valid_o held, no word skipped or duplicated.
- Protocol and reset:
  - word_valid_i pulse during DRAIN -> output unchanged, protocol_err_o=1 until next start_i.
  - reset_n_i low after 2 ACCUM words -> busy_o=0, res_valid_o=0, all outputs 0.
  - A fresh run after the reset produces correct output.
